spi_controller: RTL and testbench
=================================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter: CLK_DIV, default 4, SCLK half-period in clk cycles; legal range 2..255.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  write request; single-cycle pulse or level.
REQ-005 addr  input  7  target register address.
REQ-006 wdata  input  8  data byte to write.
REQ-007 busy  output  1  high while a transaction is in progress.
REQ-008 done  output  1  one-cycle pulse at transaction completion.
REQ-009 SCLK  output  1  SPI serial clock, mode 0 (idle low).
REQ-010 COPI  output  1  SPI controller-out data, MSB first.
REQ-011 nCS  output  1  SPI chip select, active-low.

Function
REQ-012 Frame SHALL be 16 bits, sent in order: bit15 = 1 (write), bits14..8 = addr[6:0], bits7..0 = wdata[7:0].
REQ-013 States SHALL be IDLE, SETUP, SHIFT, HOLD, GAP; IDLE is the only state with busy low.
REQ-014 IDLE: start=1 SHALL latch {1, addr, wdata} into a 16-bit shift register and move to SETUP next cycle; addr/wdata changes after that cycle SHALL NOT affect the frame.
REQ-015 start while busy=1 SHALL be ignored; no queuing.
REQ-016 SETUP: nCS=0, SCLK=0, COPI=frame bit15 from the first SETUP cycle; lasts CLK_DIV cycles, then SHIFT.
REQ-017 SHIFT: SCLK SHALL toggle every CLK_DIV cycles, starting low, for exactly 16 rising and 16 falling edges.
REQ-018 COPI SHALL change only in the cycle SCLK falls (never on a rising edge), presenting the next bit; it SHALL be stable for the whole SCLK high phase.
REQ-019 A 5-bit bit counter SHALL count rising edges; after the 16th falling edge the block SHALL enter HOLD.
REQ-020 HOLD: SCLK=0, nCS=0 for CLK_DIV cycles, then nCS=1 and GAP.
REQ-021 GAP: nCS=1, SCLK=0 for CLK_DIV cycles, then IDLE.
REQ-022 done SHALL pulse high for exactly one cycle, the first cycle in IDLE after GAP; busy SHALL be 0 in that cycle.
REQ-023 start asserted in the done cycle SHALL be accepted (back-to-back frames, nCS high for at least CLK_DIV+1 cycles between frames).
REQ-024 nCS low duration SHALL be exactly 34*CLK_DIV cycles per frame.
REQ-025 busy SHALL be high from the cycle after start is accepted through the last GAP cycle.
REQ-026 Divider counter SHALL be 8 bits and reload to 0 on every phase/state change.
REQ-027 In IDLE, COPI SHALL be 0.
REQ-028 All outputs SHALL be registered (no combinational path from inputs to outputs).

Reset
REQ-029 On rst_n=0 at a clk edge: state=IDLE, nCS=1, SCLK=0, COPI=0, busy=0, done=0, counters and shift register = 0.
REQ-030 Reset mid-frame SHALL abort immediately: nCS high and SCLK low from the next edge, no done pulse; a partial frame is discarded.
REQ-031 start sampled while rst_n=0 SHALL be ignored.

Verification
REQ-032 CLK_DIV=4, start with addr=0x00, wdata=0xF0 -> COPI sampled at 16 SCLK rises = 1000_0000_1111_0000; done once; busy=0 after.
REQ-033 CLK_DIV=4, addr=0x04, wdata=0x80 -> nCS low exactly 136 cycles, 16 SCLK rising edges, COPI never changes while SCLK high; GAP of 4 cycles before done.
REQ-034 start pulsed again at cycle 20 of a frame with addr=0x7F, wdata=0xAA -> ignored; frame completes with original values; only one done.
REQ-035 rst_n=0 at cycle 50 of a frame -> next edge nCS=1, SCLK=0, busy=0, done never asserted; new start after reset sends a full correct frame.
REQ-036 start held high continuously, addr=0x02/wdata=0x55 -> frames back-to-back, each re-latched in its done cycle, nCS high 5 cycles between frames, one done per frame.
REQ-037 Loopback: spi_controller driving spi_peripheral (CLK_DIV=2 and 4), writes to addr 0x00..0x04 -> each peripheral register reads back the written byte; writes to addr 0x05 -> no register changes.

Source files
------------

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 write-only controller sending {1, addr[6:0], wdata[7:0]} MSB first.
module spi_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       SCLK,
    output logic       COPI,
    output logic       nCS
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    state_t      state, state_n;
    logic [7:0]  div, div_n;
    logic [4:0]  bits, bits_n;
    logic [15:0] sh, sh_n;
    logic        sclk_n;
    logic        tick;
    assign tick = div == 8'(CLK_DIV - 1);
    always_comb begin
        state_n = state;
        div_n   = div + 8'd1;
        bits_n  = bits;
        sh_n    = sh;
        sclk_n  = SCLK;
        case (state)
            IDLE: begin
                div_n = '0;
                if (start) begin
                    state_n = SETUP;
                    sh_n    = {1'b1, addr, wdata};
                    bits_n  = '0;
                end
            end
            SETUP: if (tick) begin
                state_n = SHIFT;
                div_n   = '0;
            end
            SHIFT: if (tick) begin
                div_n  = '0;
                sclk_n = !SCLK;
                if (!SCLK) begin
                    bits_n = bits + 5'd1;
                end else begin
                    // falling edge: present the next bit, leave after the 16th
                    sh_n = {sh[14:0], 1'b0};
                    if (bits == 5'd16) state_n = HOLD;
                end
            end
            HOLD: if (tick) begin
                state_n = GAP;
                div_n   = '0;
            end
            GAP: if (tick) begin
                state_n = IDLE;
                div_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end
    // outputs are flops loaded from next-state values so they line up with the state change
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            div   <= '0;
            bits  <= '0;
            sh    <= '0;
            SCLK  <= 1'b0;
            COPI  <= 1'b0;
            nCS   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            div   <= div_n;
            bits  <= bits_n;
            sh    <= sh_n;
            SCLK  <= sclk_n;
            COPI  <= state_n == IDLE ? 1'b0 : sh_n[15];
            nCS   <= !(state_n == SETUP || state_n == SHIFT || state_n == HOLD);
            busy  <= state_n != IDLE;
            done  <= state == GAP && state_n == IDLE;
        end
    end
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: random and directed stimulus on CLK_DIV=4 and CLK_DIV=2 controllers,
// checked per cycle against a frame-timing model and through a loopback register peripheral.
module tb_spi_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    int         vectors = 0;
    int         errors = 0;
    logic [7:0] regs_got [2][5] = '{default: '0};
    logic [7:0] regs_exp [2][5] = '{default: '0};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int D = k == 0 ? 4 : 2;
        logic        busy, done, sclk, copi, ncs;
        bit          act = 1'b0;
        int          p = 0;
        logic [15:0] frame = '0;
        logic [15:0] sr = '0;
        int          cnt = 0;

        spi_controller #(.CLK_DIV(D)) dut (
            .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .wdata(wdata),
            .busy(busy), .done(done), .SCLK(sclk), .COPI(copi), .nCS(ncs)
        );

        function automatic void wr(input logic [15:0] f);
            int a = int'(f[14:8]);
            if (a < 5) regs_exp[k][a] = f[7:0];
        endfunction

        // p = cycles since the accepting edge; frame occupies 35*D cycles, then the done cycle
        always @(posedge clk) begin
            if (!rst_n) begin
                if (act && p >= 32 * D && p < 34 * D) wr(frame);
                act = 1'b0;
            end else if ((!act || p == 35 * D) && start) begin
                act = 1'b1;
                p = 0;
                frame = {1'b1, addr, wdata};
            end else if (act) begin
                p++;
                if (p == 34 * D) wr(frame);
                if (p > 35 * D) act = 1'b0;
            end
        end

        function automatic logic [4:0] expv();
            int   i;
            logic s, c;
            if (!act) return 5'b00001;
            if (p == 35 * D) return 5'b01001;
            i = p < D ? 0 : (p - D) / (2 * D);
            s = p >= D && p < 33 * D && ((p - D) / D) % 2 == 1;
            c = i < 16 ? frame[15 - i] : 1'b0;
            return {1'b1, 1'b0, s, c, p >= 34 * D};
        endfunction

        always @(negedge clk)
            check(k == 0 ? "out_div4" : "out_div2", 16'({busy, done, sclk, copi, ncs}), 16'(expv()));

        always @(negedge ncs) cnt = 0;
        always @(posedge sclk) if (!ncs) begin
            sr = {sr[14:0], copi};
            cnt++;
        end
        always @(posedge ncs) if (cnt == 16 && sr[15] && sr[14:8] < 7'd5) regs_got[k][sr[14:8]] = sr[7:0];
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [6:0] a, input logic [7:0] d);
        addr = a;
        wdata = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        idle(3);
        rst_n = 1'b1;
        pulse(7'h00, 8'hF0);
        idle(160);
        pulse(7'h04, 8'h80);
        idle(160);
        pulse(7'h01, 8'h11);
        idle(19);
        pulse(7'h7F, 8'hAA);
        idle(160);
        pulse(7'h02, 8'h22);
        idle(49);
        rst_n = 1'b0;
        start = 1'b1;
        idle(1);
        rst_n = 1'b1;
        start = 1'b0;
        idle(5);
        pulse(7'h01, 8'h3C);
        idle(160);
        addr = 7'h02;
        wdata = 8'h55;
        start = 1'b1;
        idle(3 * 141 + 10);
        start = 1'b0;
        idle(160);
        repeat (40) begin
            repeat ($urandom_range(20, 300)) begin
                start = $urandom_range(0, 9) < 2;
                addr = 7'($urandom_range(0, 5));
                wdata = 8'($urandom);
                @(negedge clk);
            end
            start = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                rst_n = 1'b0;
                idle(1);
                rst_n = 1'b1;
            end
        end
        start = 1'b0;
        idle(200);
        for (int j = 0; j < 5; j++) begin
            check("reg_div4", 16'(regs_got[0][j]), 16'(regs_exp[0][j]));
            check("reg_div2", 16'(regs_got[1][j]), 16'(regs_exp[1][j]));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
